// File: rtl/core_pkg.sv
// Shared control-bundle layout, forwarding encodings and bubble constant
// for the 5-stage RV32I pipeline.
package core_pkg;

    localparam int CTRL_W        = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [CTRL_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding select for one source register.
// The newer EX/MEM result wins over MEM/WB; x0 never forwards.
module fwd_unit
    import core_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            wb_regwrite,
    input  logic [RA_W-1:0] wb_rd,
    output logic [1:0]      sel
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == rs);
        wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == rs);
        sel     = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID/EX -> EX/MEM -> MEM/WB with load-use stall,
// redirect flush and EX operand forwarding selects.
module ctrl_pipe_hazard
    import core_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      id_ctrl,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            ex_redirect,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            ifid_flush,
    output logic            ex_alusrc,
    output logic [1:0]      ex_aluop,
    output logic            ex_branch,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic [RA_W-1:0] ex_rd,
    output logic [RA_W-1:0] mem_rd,
    output logic [RA_W-1:0] wb_rd,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    logic [7:0]      idex_ctrl_q, idex_ctrl_d;
    logic [RA_W-1:0] idex_rs1_q, idex_rs1_d;
    logic [RA_W-1:0] idex_rs2_q, idex_rs2_d;
    logic [RA_W-1:0] idex_rd_q, idex_rd_d;
    // EX/MEM: {MemtoReg, RegWrite, MemRead, MemWrite}
    logic [3:0]      exmem_ctrl_q, exmem_ctrl_d;
    logic [RA_W-1:0] exmem_rd_q, exmem_rd_d;
    // MEM/WB: {MemtoReg, RegWrite}
    logic [1:0]      memwb_ctrl_q, memwb_ctrl_d;
    logic [RA_W-1:0] memwb_rd_q, memwb_rd_d;

    logic lu;
    logic bubble;

    always_comb begin
        lu = idex_ctrl_q[CTRL_MEMREAD] && (idex_rd_q != '0) &&
             ((idex_rd_q == id_rs1) || (idex_rd_q == id_rs2));
        bubble = ex_redirect || lu;

        pc_write   = ex_redirect || !lu;
        ifid_write = ex_redirect || !lu;
        ifid_flush = ex_redirect;

        idex_ctrl_d = id_ctrl;
        idex_rs1_d  = id_rs1;
        idex_rs2_d  = id_rs2;
        idex_rd_d   = id_rd;
        if (bubble) begin
            idex_ctrl_d = BUBBLE;
            idex_rs1_d  = '0;
            idex_rs2_d  = '0;
            idex_rd_d   = '0;
        end

        exmem_ctrl_d = {idex_ctrl_q[CTRL_MEMTOREG], idex_ctrl_q[CTRL_REGWRITE],
                        idex_ctrl_q[CTRL_MEMREAD], idex_ctrl_q[CTRL_MEMWRITE]};
        exmem_rd_d   = idex_rd_q;
        memwb_ctrl_d = exmem_ctrl_q[3:2];
        memwb_rd_d   = exmem_rd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_ctrl_q  <= BUBBLE;
            idex_rs1_q   <= '0;
            idex_rs2_q   <= '0;
            idex_rd_q    <= '0;
            exmem_ctrl_q <= '0;
            exmem_rd_q   <= '0;
            memwb_ctrl_q <= '0;
            memwb_rd_q   <= '0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rs1_q   <= idex_rs1_d;
            idex_rs2_q   <= idex_rs2_d;
            idex_rd_q    <= idex_rd_d;
            exmem_ctrl_q <= exmem_ctrl_d;
            exmem_rd_q   <= exmem_rd_d;
            memwb_ctrl_q <= memwb_ctrl_d;
            memwb_rd_q   <= memwb_rd_d;
        end
    end

    assign ex_alusrc    = idex_ctrl_q[CTRL_ALUSRC];
    assign ex_aluop     = idex_ctrl_q[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    assign ex_branch    = idex_ctrl_q[CTRL_BRANCH];
    assign mem_memread  = exmem_ctrl_q[1];
    assign mem_memwrite = exmem_ctrl_q[0];
    assign wb_memtoreg  = memwb_ctrl_q[1];
    assign wb_regwrite  = memwb_ctrl_q[0];
    assign ex_rd        = idex_rd_q;
    assign mem_rd       = exmem_rd_q;
    assign wb_rd        = memwb_rd_q;

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .rs           (idex_rs1_q),
        .mem_regwrite (exmem_ctrl_q[2]),
        .mem_rd       (exmem_rd_q),
        .wb_regwrite  (memwb_ctrl_q[0]),
        .wb_rd        (memwb_rd_q),
        .sel          (fwd_a)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .rs           (idex_rs2_q),
        .mem_regwrite (exmem_ctrl_q[2]),
        .mem_rd       (exmem_rd_q),
        .wb_regwrite  (memwb_ctrl_q[0]),
        .wb_rd        (memwb_rd_q),
        .sel          (fwd_b)
    );

endmodule

// File: doc/ctrl_pipe_hazard.md
# ctrl_pipe_hazard

Carries the decoded control bundle from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RV32I core. It detects load-use hazards and inserts one-cycle bubbles. It flushes on taken branches and jumps, and generates EX-stage operand forwarding selects. The block sits between the main control decoder (ID) and the datapath pipeline registers, and consumes every field the decoder produces.

## Interface
- `RA_W`, default 5: register-address width.
- `clk` in 1: single core clock; all state updates on rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `id_ctrl` in 8: decoder bundle `{ALUsrc, MemtoReg, RegWrite, MemRead, MemWrite, branch, ALUop[1:0]}`.
- `id_rs1`, `id_rs2`, `id_rd` in RA_W: ID-stage register fields.
- `ex_redirect` in 1: datapath's taken-branch/JAL/JALR resolution in EX.
- `pc_write` out 1: PC enable.
- `ifid_write` out 1: IF/ID register enable.
- `ifid_flush` out 1: IF/ID register clear.
- `ex_alusrc`, `ex_aluop[1:0]`, `ex_branch` out: EX-stage control.
- `mem_memread`, `mem_memwrite` out 1: MEM-stage control.
- `wb_regwrite`, `wb_memtoreg` out 1: WB-stage control.
- `ex_rd`, `mem_rd`, `wb_rd` out RA_W: destination tags per stage.
- `fwd_a`, `fwd_b` out 2: EX operand select. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.

## Operation
- Stage registers:
  - ID/EX holds the 8-bit control, rs1, rs2 and rd.
  - EX/MEM holds {MemtoReg, RegWrite, MemRead, MemWrite} and rd.
  - MEM/WB holds {MemtoReg, RegWrite} and rd.
- A bubble is all-zero control plus rd = 0.
- Load-use hazard `lu` holds when ID/EX MemRead = 1, ex_rd ≠ 0, and ex_rd equals id_rs1 or id_rs2. It is evaluated against the rs fields regardless of whether the instruction uses them; conservative stalls are acceptable.
- Priority 1, `ex_redirect` = 1:
  - ifid_flush = 1; pc_write = 1, ifid_write = 1.
  - A bubble is loaded into ID/EX; `lu` is ignored.
  - EX/MEM captures the redirecting instruction normally, so JAL/JALR link writes survive.
- Priority 2, `lu` = 1:
  - pc_write = 0, ifid_write = 0, ifid_flush = 0.
  - A bubble is loaded into ID/EX.
  - EX/MEM and MEM/WB advance.
- Otherwise: pc_write = ifid_write = 1, ifid_flush = 0, and all stages advance.
- Forwarding for operand A; operand B is identical using rs2:
  - If EX/MEM RegWrite && mem_rd ≠ 0 && mem_rd == ID/EX rs1, then 10.
  - Else if MEM/WB RegWrite && wb_rd ≠ 0 && wb_rd == ID/EX rs1, then 01.
  - Else 00.
  - EX/MEM has priority when both stages match.
- Register x0 never forwards and never triggers a stall.
- No X propagation: decoder don't-care bits are registered as received. When MemtoReg is X, the block treats it as 0 for bubble and forward decisions, because RegWrite = 0 in those encodings.

## Timing
- Reset, while rst_n = 0 at a clock edge:
  - All stage registers are cleared, so every stage holds a bubble.
  - Next cycle: all control outputs, rd outputs and fwd selects are 0; pc_write = ifid_write = 1; ifid_flush = 0.
- Reset asserted mid-stall or mid-flush discards the hazard; no stall is carried across reset.
- Control latency: ID→EX 1 cycle, →MEM 2 cycles, →WB 3 cycles.
- `pc_write`, `ifid_write`, `ifid_flush` and `fwd_*` are combinational from current state and inputs, and valid in the same cycle.
- A load-use stall lasts exactly one cycle. Next cycle the load is in MEM, `lu` deasserts and fwd selects 10 is not used; the MEM/WB path (01) is used the cycle after.
- Back-to-back loads to the same rd each stall independently, with one bubble each.
- `ex_redirect` and `lu` asserting in the same cycle produce a flush only, with pc_write = 1.

## Structure
- The shared package `core_pkg` holds:
  - Bundle bit-index constants (CTRL_ALUSRC=7 … CTRL_ALUOP=1:0).
  - Forwarding select encodings FWD_RF/FWD_MEM/FWD_WB.
  - The BUBBLE constant.
- Sub-module `fwd_unit`: purely combinational forwarding select for one operand, instantiated twice.
- The stage registers and hazard logic stay in the top.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with id_ctrl = 8'b00100010. Then all outputs are 0 except pc_write = ifid_write = 1.
- R-type flow: id_ctrl = 8'b00100010, rd = 5 at cycle 0. Then ex_aluop = 10 at cycle 1, wb_regwrite = 1 and wb_rd = 5 at cycle 3.
- Load-use: a load with rd = 3 (8'b11110000) followed by an R-type with rs1 = 3. Then pc_write = ifid_write = 0 for exactly 1 cycle, one bubble in EX, and fwd_a = 01 when the R-type reaches EX.
- Forward priority: consecutive writes to x7 followed by a reader of x7. Then fwd_a = 10. With rd = 0 instead, fwd_a = 00 and no stall.
- Redirect: ex_redirect = 1 together with a simultaneous load-use condition. Then ifid_flush = 1, pc_write = 1, a bubble in EX, and the JAL's RegWrite reaches WB 2 cycles later.
- Mid-stall reset: assert rst_n = 0 during a load-use stall cycle. Next cycle all stages hold bubbles and pc_write = 1.
